// File: rtl/gol_pkg.sv
// Shared definitions for the game-of-life board streamer.
// Holds the streamer FSM state type, the row width, the default sync byte
// and a helper that returns the frame length in bytes.
package gol_pkg;

    localparam int ROW_BITS = 8;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_GEN,
        ST_ROW,
        ST_CSUM
    } stream_state_e;

    // A frame is the sync byte, the gen byte, one byte per row and an
    // optional checksum byte.
    function automatic int frame_len(input int board_h, input bit csum_en);
        return board_h + (csum_en ? 3 : 2);
    endfunction

endpackage

// File: rtl/gol_board_streamer.sv
// Snapshots the life board on each generation tick and streams it as a
// byte-wide valid/ready frame: sync, generation number, rows 0..BOARD_H-1
// and, when GOL_STREAM_CHECKSUM_EN is defined, an XOR checksum byte.
// Ticks that arrive mid-frame are counted but their frame is dropped.
module gol_board_streamer
    import gol_pkg::*;
#(
    parameter int         BOARD_H   = 8,
    parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [ROW_BITS*BOARD_H-1:0]  i_board,
    input  logic                         i_gen_tick,
    output logic [7:0]                   o_data,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic                         o_busy,
    output logic                         o_dropped,
    output logic [7:0]                   o_gen_count
);

    localparam int IDX_W = (BOARD_H > 1) ? $clog2(BOARD_H) : 1;
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(BOARD_H - 1);

    stream_state_e                 state_q, state_d;
    logic [ROW_BITS*BOARD_H-1:0]   snap_q, snap_d;
    logic [7:0]                    gen_byte_q, gen_byte_d;
    logic [7:0]                    gen_count_q, gen_count_d;
    logic [IDX_W-1:0]              row_q, row_d;
    logic                          dropped_q, dropped_d;
`ifdef GOL_STREAM_CHECKSUM_EN
    logic [7:0]                    csum_q, csum_d;
`endif

    logic       xfer;
    logic       frame_done;
    logic       accept;
    logic [7:0] row_byte;

    // Output byte mux; valid is derived from state alone so it never
    // depends on the sink's ready.
    always_comb begin
        row_byte = snap_q[int'(row_q)*ROW_BITS +: ROW_BITS];
        o_valid  = (state_q != ST_IDLE);
        o_busy   = (state_q != ST_IDLE);
        o_data   = 8'h00;
        case (state_q)
            ST_SYNC: o_data = SYNC_BYTE;
            ST_GEN:  o_data = gen_byte_q;
            ST_ROW:  o_data = row_byte;
`ifdef GOL_STREAM_CHECKSUM_EN
            ST_CSUM: o_data = csum_q;
`endif
            default: o_data = 8'h00;
        endcase
        o_dropped   = dropped_q;
        o_gen_count = gen_count_q;
    end

    // A tick is taken when idle or on the final transfer of a frame, so
    // back-to-back frames run without a gap; any other tick is dropped.
    always_comb begin
        xfer = o_valid && i_ready;
`ifdef GOL_STREAM_CHECKSUM_EN
        frame_done = xfer && (state_q == ST_CSUM);
`else
        frame_done = xfer && (state_q == ST_ROW) && (row_q == LAST_ROW);
`endif
        accept = i_gen_tick && ((state_q == ST_IDLE) || frame_done);
    end

    // Next-state logic: walk the frame one byte per transfer, then let an
    // accepted tick override everything with a fresh snapshot.
    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        gen_byte_d  = gen_byte_q;
        row_d       = row_q;
        gen_count_d = gen_count_q + {7'd0, i_gen_tick};
        dropped_d   = i_gen_tick && !accept;
`ifdef GOL_STREAM_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_SYNC: if (xfer) state_d = ST_GEN;
            ST_GEN: begin
                if (xfer) begin
                    state_d = ST_ROW;
                    row_d   = '0;
                end
            end
            ST_ROW: begin
                if (xfer) begin
`ifdef GOL_STREAM_CHECKSUM_EN
                    csum_d = csum_q ^ row_byte;
`endif
                    if (row_q == LAST_ROW) begin
`ifdef GOL_STREAM_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
`ifdef GOL_STREAM_CHECKSUM_EN
            ST_CSUM: if (xfer) state_d = ST_IDLE;
`endif
            default: state_d = ST_IDLE;
        endcase
        if (accept) begin
            state_d    = ST_SYNC;
            snap_d     = i_board;
            gen_byte_d = gen_count_q;
            row_d      = '0;
`ifdef GOL_STREAM_CHECKSUM_EN
            csum_d     = gen_count_q;
`endif
        end
    end

    // State registers; reset abandons any partial frame.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= ST_IDLE;
            snap_q      <= '0;
            gen_byte_q  <= 8'h00;
            gen_count_q <= 8'h00;
            row_q       <= '0;
            dropped_q   <= 1'b0;
`ifdef GOL_STREAM_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            snap_q      <= snap_d;
            gen_byte_q  <= gen_byte_d;
            gen_count_q <= gen_count_d;
            row_q       <= row_d;
            dropped_q   <= dropped_d;
`ifdef GOL_STREAM_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule
